// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, the queue entry type and a depth-to-pointer-width
// helper for the fetch queue.
//   D              program counter / instruction address width
//   W              instruction word width
//   fetch_entry_t  one queued instruction together with its address
//   clog2_depth    pointer width for a power-of-two queue depth
package fetch_pkg;

  localparam int D = 12;
  localparam int W = 9;

  typedef struct packed {
    logic [W-1:0] inst;
    logic [D-1:0] pc;
  } fetch_entry_t;

  function automatic int clog2_depth(input int depth);
    int bits;
    bits = 0;
    while ((1 << bits) < depth) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: every signal the fetch queue exchanges with its neighbours.
// The master modport is the fetch queue itself. The slave modport is the
// environment: the PC register, instruction memory and decode.
//   pc_in, pc_advance         PC register handshake
//   redirect                  start or taken branch; flushes the queue
//   imem_en, imem_addr,
//   imem_rdata                instruction memory read (data arrives 1 cycle later)
//   inst_out, inst_pc,
//   inst_valid, inst_ready    head of the queue towards decode
interface fetch_queue_if;
  import fetch_pkg::*;

  logic [D-1:0] pc_in;
  logic         pc_advance;
  logic         redirect;
  logic         imem_en;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_rdata;
  logic [W-1:0] inst_out;
  logic [D-1:0] inst_pc;
  logic         inst_valid;
  logic         inst_ready;

  modport master (
    input  pc_in, redirect, imem_rdata, inst_ready,
    output pc_advance, imem_en, imem_addr, inst_out, inst_pc, inst_valid
  );

  modport slave (
    output pc_in, redirect, imem_rdata, inst_ready,
    input  pc_advance, imem_en, imem_addr, inst_out, inst_pc, inst_valid
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: storage for the fetch queue. It holds the pointers, the
// occupancy count, and push/pop/flush handling.
//   clk, reset_n   clock and asynchronous active-low reset
//   flush          empty the queue; overrides push and pop on the same edge
//   push, push_data  write one entry at the tail
//   pop            remove the head; ignored when the queue is empty
//   head           current head entry; holds its last value when empty
//   count          number of valid entries (0..DEPTH)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = clog2_depth(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_hold_q, head_hold_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head        = head_hold_q;
    head_hold_d = head_hold_q;

    // While the queue is empty the head holds the last entry it showed.
    if (count_q != '0) head = mem_q[rd_ptr_q];
    head_hold_d = head;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly AW bits wide, so the increment wraps mod DEPTH.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_hold_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_hold_q <= head_hold_d;
    end
  end

  // NOTE: the storage array has no reset. An entry is only read after it has
  // been written, because the head is gated by count, so clearing it would add
  // reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: consumer side of the PC interface. It reads pc_in, issues
// instruction memory reads, and buffers the returned instructions with their
// addresses for decode.
//   clk, reset_n  clock and asynchronous active-low reset
//   bus           fetch_queue_if.master (PC handshake, imem read port,
//                 decode handshake)
// A read issued at one edge returns its data in the next cycle, and that data
// is captured at the following edge. The issue rule counts the read in flight
// as occupied, so a response always finds a free slot.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_queue_if.master bus
);

  localparam int CW = clog2_depth(DEPTH) + 1;

  logic          inflight_q, inflight_d;
  logic [D-1:0]  inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  capture_entry;
  logic          issue;
  logic          capture;

  // A redirect or reset stops issue immediately. Otherwise a read is issued
  // whenever queued plus in-flight entries leave a free slot.
  assign issue = reset_n & ~bus.redirect
               & ((int'(fifo_count) + int'(inflight_q)) < DEPTH);

  // A response still in flight during a redirect belongs to the old stream
  // and is dropped.
  assign capture = inflight_q & ~bus.redirect;

  assign capture_entry = '{inst: bus.imem_rdata, pc: inflight_pc_q};

  always_comb begin
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) inflight_pc_d = bus.pc_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.redirect),
    .push      (capture),
    .push_data (capture_entry),
    .pop       (bus.inst_ready),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.imem_en    = issue;
  assign bus.pc_advance = issue;
  assign bus.imem_addr  = bus.pc_in;
  assign bus.inst_out   = fifo_head.inst;
  assign bus.inst_pc    = fifo_head.pc;
  assign bus.inst_valid = (fifo_count != '0);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue. It contains a simple PC
// register (advances on pc_advance, or loads a target) and a one-cycle
// latency ROM with ROM[a] = a[8:0] + 9'h100.
module tb_fetch_queue;

  logic clk = 1'b0;
  logic reset_n;
  logic pc_load;
  logic [11:0] pc_load_val;
  logic [11:0] pc_q;

  int errors = 0;
  int checks = 0;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.pc_in = pc_q;

  always @(posedge clk) begin
    if (pc_load) pc_q <= pc_load_val;
    else if (bus.pc_advance) pc_q <= pc_q + 12'd1;
  end

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= bus.imem_addr[8:0] + 9'h100;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [11:0] pc, input logic [8:0] inst);
    check({tag, ".valid"}, 32'(bus.inst_valid), 32'd1);
    check({tag, ".pc"},    32'(bus.inst_pc),    32'(pc));
    check({tag, ".inst"},  32'(bus.inst_out),   32'(inst));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: everything quiet, head reads zero.
    reset_n      = 1'b0;
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b1;
    pc_load      = 1'b1;
    pc_load_val  = 12'd0;
    #1;
    check("rst.valid",   32'(bus.inst_valid), 32'd0);
    check("rst.imem_en", 32'(bus.imem_en),    32'd0);
    check("rst.adv",     32'(bus.pc_advance), 32'd0);
    check("rst.inst",    32'(bus.inst_out),   32'd0);
    check("rst.pc",      32'(bus.inst_pc),    32'd0);
    step();
    step();

    // Stream from PC 0 with decode always ready.
    pc_load = 1'b0;
    reset_n = 1'b1;
    #1;
    check("s.imem_en0", 32'(bus.imem_en),   32'd1);
    check("s.addr0",    32'(bus.imem_addr), 32'd0);
    check("s.valid0",   32'(bus.inst_valid), 32'd0);
    step();
    check("s.valid1", 32'(bus.inst_valid), 32'd0);
    check("s.addr1",  32'(bus.imem_addr),  32'd1);
    step();
    check_head("s.h0", 12'd0, 9'h100);
    for (int k = 1; k <= 8; k++) begin
      step();
      check_head("s.h", 12'(k), 9'(9'h100 + k));
    end

    // Backpressure: restart at 0 with decode stalled.
    bus.redirect   = 1'b1;
    pc_load        = 1'b1;
    pc_load_val    = 12'd0;
    bus.inst_ready = 1'b0;
    #1;
    check("bp.redir_en",  32'(bus.imem_en),    32'd0);
    check("bp.redir_adv", 32'(bus.pc_advance), 32'd0);
    step();
    bus.redirect = 1'b0;
    pc_load      = 1'b0;
    #1;
    check("bp.flushed", 32'(bus.inst_valid), 32'd0);
    for (int k = 0; k < 4; k++) step();
    check("bp.adv_full", 32'(bus.pc_advance), 32'd0);
    check("bp.pc_hold",  32'(pc_q),           32'd4);
    step();
    check("bp.adv_full2", 32'(bus.pc_advance), 32'd0);
    check_head("bp.h0", 12'd0, 9'h100);
    step();
    step();
    check("bp.pc_hold2", 32'(pc_q), 32'd4);
    check_head("bp.h0b", 12'd0, 9'h100);
    bus.inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_head("bp.drain", 12'(k), 9'(9'h100 + k));
    end

    // Redirect with a read in flight: 3,4 queued, 5 in flight, PC at 6.
    bus.redirect   = 1'b1;
    pc_load        = 1'b1;
    pc_load_val    = 12'd3;
    bus.inst_ready = 1'b0;
    step();
    bus.redirect = 1'b0;
    pc_load      = 1'b0;
    step();
    step();
    step();
    check("rd.pc", 32'(pc_q), 32'd6);
    check_head("rd.h3", 12'd3, 9'h103);
    bus.redirect   = 1'b1;
    pc_load        = 1'b1;
    pc_load_val    = 12'd16;
    bus.inst_ready = 1'b1;
    #1;
    check("rd.en_off",  32'(bus.imem_en),    32'd0);
    check("rd.adv_off", 32'(bus.pc_advance), 32'd0);
    step();
    bus.redirect = 1'b0;
    pc_load      = 1'b0;
    #1;
    check("rd.empty",   32'(bus.inst_valid), 32'd0);
    check("rd.en_new",  32'(bus.imem_en),    32'd1);
    check("rd.addr16",  32'(bus.imem_addr),  32'd16);
    step();
    check("rd.dropped", 32'(bus.inst_valid), 32'd0);
    step();
    check_head("rd.h16", 12'd16, 9'h110);
    step();
    check_head("rd.h17", 12'd17, 9'h111);

    // Full queue, then pop on the same edge as a capture; run across wraps.
    bus.redirect   = 1'b1;
    pc_load        = 1'b1;
    pc_load_val    = 12'd32;
    bus.inst_ready = 1'b0;
    step();
    bus.redirect = 1'b0;
    pc_load      = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("fu.adv_full", 32'(bus.pc_advance), 32'd0);
    check("fu.pc",       32'(pc_q),           32'd36);
    check_head("fu.h32", 12'd32, 9'h120);
    bus.inst_ready = 1'b1;
    for (int k = 33; k <= 46; k++) begin
      step();
      check_head("fu.wrap", 12'(k), 9'(9'h100 + k));
    end

    // Asynchronous reset between edges with 3 entries queued.
    bus.redirect   = 1'b1;
    pc_load        = 1'b1;
    pc_load_val    = 12'd64;
    bus.inst_ready = 1'b0;
    step();
    bus.redirect = 1'b0;
    pc_load      = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check_head("ar.h64", 12'd64, 9'h140);
    #2;
    reset_n     = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = 12'd128;
    #1;
    check("ar.valid",   32'(bus.inst_valid), 32'd0);
    check("ar.imem_en", 32'(bus.imem_en),    32'd0);
    check("ar.adv",     32'(bus.pc_advance), 32'd0);
    check("ar.inst",    32'(bus.inst_out),   32'd0);
    step();
    step();
    pc_load        = 1'b0;
    reset_n        = 1'b1;
    bus.inst_ready = 1'b1;
    #1;
    check("ar.en_restart", 32'(bus.imem_en),   32'd1);
    check("ar.addr128",    32'(bus.imem_addr), 32'd128);
    step();
    check("ar.valid_lat", 32'(bus.inst_valid), 32'd0);
    step();
    check_head("ar.h128", 12'd128, 9'h180);
    step();
    check_head("ar.h129", 12'd129, 9'h181);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer side of the program-counter interface: reads the current PC, issues instruction-memory reads, and buffers returned instructions with their addresses in a small FIFO.
- Sits between the PC/nextPC pair and decode.
- Tells the PC when to advance (`pc_advance`).
- Discards stale work on a redirect (start or taken branch).

Parameters:
- D, 12, PC / instruction address width.
- W, 9, instruction word width.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- pc_in  in  D  current program counter (PC register output).
- pc_advance  out  1  PC may load its next value this edge.
- redirect  in  1  start or taken branch this cycle; flush everything.
- imem_en  out  1  instruction-memory read enable.
- imem_addr  out  D  read address (equals pc_in when imem_en=1).
- imem_rdata  in  W  read data, valid exactly 1 cycle after imem_en.
- inst_out  out  W  head instruction.
- inst_pc  out  D  address of head instruction.
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (reset_n=0, async):
  - queue empty, in-flight flag cleared.
  - inst_valid=0, inst_out=0, inst_pc=0, imem_en=0, pc_advance=0.
- State: count (0..DEPTH), rd/wr pointers (log2 DEPTH, wrap), inflight bit, inflight_pc[D].
- Issue rule (combinational):
  - imem_en = pc_advance = reset_n & ~redirect & (count + inflight < DEPTH).
  - imem_addr = pc_in.
- Issue edge: when imem_en=1, set inflight=1 and inflight_pc=pc_in; otherwise inflight=0.
- Capture edge: if inflight=1 and no redirect, write {imem_rdata, inflight_pc} at wr_ptr; wr_ptr++ (mod DEPTH).
- Pop edge: inst_valid & inst_ready pops the head; rd_ptr++.
- Push and pop on the same edge: count unchanged; allowed when full because of the issue rule.
- Head outputs are registered-array reads at rd_ptr.
  - inst_valid = (count != 0).
  - When count==0, inst_out and inst_pc hold their last value; decode must not sample them.
- Latency: pc_in sampled at edge N appears at the head after edge N+1 if the queue was empty (2 cycles from issue to inst_valid).
- Redirect (priority over everything):
  - Combinationally forces imem_en=0 and pc_advance=0.
  - At the edge: count=0, rd=wr=0, inflight=0; the in-flight response is dropped, and any pop that cycle is ignored.
  - Next cycle: issue from the new pc_in.
- Full: count + inflight == DEPTH forces pc_advance=0; the PC holds, and nothing is lost.
- Empty with inst_ready=1: no pop and no pointer change.
- Wrap: pointers wrap mod DEPTH; address arithmetic is never done here (PC increments are nextPC's job).
- reset_n deassert mid-stream: first issue happens on the first edge with reset_n=1.

Decomposition:
- Package fetch_pkg holds:
  - localparams D and W;
  - typedef `fetch_entry_t` = struct {logic [W-1:0] inst; logic [D-1:0] pc};
  - function `clog2_depth`.
- Sub-module `fetch_fifo` (storage, pointers, count, push/pop/flush) is natural.
- Top level holds the issue/inflight logic.

Test Plan:
- Reset then stream:
  - Stimulus: reset_n low 2 cycles; PC advances 0,1,2,3,…; ROM[a]=a+9'h100; inst_ready=1.
  - Response: inst_valid first rises 2 cycles after the first issue; pairs (0,0x100),(1,0x101),… arrive one per cycle, no gaps.
- Backpressure:
  - Stimulus: inst_ready=0 from the start.
  - Response: pc_advance drops after 4 issues; count=4; the PC holds at 4.
  - Then inst_ready=1: entries 0..3 drain in order, then 4 follows with no loss or duplicate.
- Redirect with in-flight read:
  - Stimulus: at PC=5 with 2 queued entries, pulse redirect while the PC loads 16.
  - Response: queue empties; response for 5 is dropped; next head is (16, ROM[16]) 2 cycles later.
- Simultaneous push/pop when full:
  - Stimulus: fill to 4, then inst_ready=1 on the same cycle as a capture.
  - Response: count stays 4; order is preserved across pointer wrap (≥3 wraps checked).
- Async reset mid-operation:
  - Stimulus: assert reset_n between edges with 3 entries queued.
  - Response: inst_valid, imem_en and pc_advance go 0 immediately; after release, fetch restarts from the current pc_in (128).
